// File: rtl/mem_resp_if.sv
// Single-port memory bus between an initiator (master) and mem_resp_ctrl (slave).
interface mem_resp_if #(
    parameter int P_MEM_DW = 8,
    parameter int P_MEM_AW = 5
);
    logic                m_cs;
    logic                m_rw;
    logic [P_MEM_AW-1:0] m_addr;
    logic [P_MEM_DW-1:0] m_wdata;
    logic [P_MEM_DW-1:0] m_rdata;
    logic                m_ready;
    logic                m_perr;

    modport master (
        output m_cs, m_rw, m_addr, m_wdata,
        input  m_rdata, m_ready, m_perr
    );

    modport slave (
        input  m_cs, m_rw, m_addr, m_wdata,
        output m_rdata, m_ready, m_perr
    );
endinterface

// File: rtl/mem_resp_ctrl.sv
// Timed, handshaked memory responder: one-cycle writes, P_RD_LAT-cycle reads.
// Optional MEM_RESP_PARITY_EN adds a stored even-parity bit per word and drives m_perr.
module mem_resp_ctrl #(
    parameter int P_MEM_DW = 8,
    parameter int P_MEM_AW = 5,
    parameter int P_RD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_resp_if.slave  bus
);
    localparam int DEPTH = 1 << P_MEM_AW;
    localparam int CW    = $clog2(P_RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, DONE} state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [P_MEM_AW-1:0] addr_q, addr_nx;
    logic [P_MEM_AW-1:0] rd_addr;
    logic [P_MEM_DW-1:0] mem [DEPTH];
    logic [P_MEM_DW-1:0] rdata_q;
    logic                ready_q, ready_nx;
    logic                mem_we, rd_load;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = addr_q;
        rd_addr  = addr_q;
        mem_we   = 1'b0;
        rd_load  = 1'b0;
        ready_nx = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m_cs) begin
                    if (!bus.m_rw) begin
                        mem_we   = 1'b1;
                        ready_nx = 1'b1;
                        state_nx = DONE;
                    end else begin
                        addr_nx = bus.m_addr;
                        if (P_RD_LAT == 1) begin
                            // single-cycle read bypasses the latched address
                            rd_addr  = bus.m_addr;
                            rd_load  = 1'b1;
                            ready_nx = 1'b1;
                            state_nx = DONE;
                        end else begin
                            cnt_nx   = CW'(P_RD_LAT - 1);
                            state_nx = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (!bus.m_cs) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (cnt == CW'(1)) begin
                    cnt_nx   = '0;
                    rd_load  = 1'b1;
                    ready_nx = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            DONE: begin
                if (!bus.m_cs) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            addr_q  <= addr_nx;
            ready_q <= ready_nx;
            if (rd_load) rdata_q <= mem[rd_addr];
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) mem[bus.m_addr] <= bus.m_wdata;
    end

    assign bus.m_rdata = rdata_q;
    assign bus.m_ready = ready_q;

`ifdef MEM_RESP_PARITY_EN
    logic mem_par [DEPTH];
    logic perr_q;

    always_ff @(posedge clk) begin
        if (mem_we) mem_par[bus.m_addr] <= ^bus.m_wdata;
    end

    // Flag is only ever high alongside the read-completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_q <= 1'b0;
        else        perr_q <= rd_load && ((^mem[rd_addr]) != mem_par[rd_addr]);
    end

    assign bus.m_perr = perr_q;
`else
    assign bus.m_perr = 1'b0;
`endif
endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Scoreboard bench: three responders (P_RD_LAT = 1, 2, 4) run in lockstep on one stimulus stream.
module tb_mem_resp_ctrl;
    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       perr;
        logic       is_rd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic       rw = 1'b0;
    logic [4:0] addr = '0;
    logic [7:0] wdata = '0;

    logic [7:0] rdata [3];
    logic       ready [3];
    logic       perr  [3];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q0[$], q1[$], q2[$];
    logic [7:0] smem [32];
    logic       sbad [32];
    logic       written [32];
    logic [7:0] last_rd [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        mem_resp_if #(.P_MEM_DW(8), .P_MEM_AW(5)) bus ();
        assign bus.m_cs    = cs;
        assign bus.m_rw    = rw;
        assign bus.m_addr  = addr;
        assign bus.m_wdata = wdata;
        assign rdata[g]    = bus.m_rdata;
        assign ready[g]    = bus.m_ready;
        assign perr[g]     = bus.m_perr;
        mem_resp_ctrl #(.P_MEM_DW(8), .P_MEM_AW(5), .P_RD_LAT(L)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic push_exp(input int d, input exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int d, output exp_t e, output bit ok);
        ok = 1'b0;
        case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : ((d == 1) ? q1.size() : q2.size());
    endfunction

    // Completion monitor: every m_ready must match the oldest expected entry.
    always @(negedge clk) begin : mon
        exp_t e;
        bit   ok;
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (ready[d]) begin
                    pop_exp(d, e, ok);
                    if (!ok) begin
                        chk($sformatf("spurious_ready_lat%0d", lat_of(d)), ready[d], 0);
                    end else begin
                        chk($sformatf("ready_cycle_lat%0d", lat_of(d)), cyc, e.cyc);
                        if (e.is_rd)
                            chk($sformatf("rdata_lat%0d", lat_of(d)), rdata[d], e.data);
                        chk($sformatf("perr_lat%0d", lat_of(d)), perr[d], e.perr);
                    end
                end
            end
        end
    end

    task automatic settle_checks(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_missing_ready_lat%0d", tag, lat_of(d)), qsize(d), 0);
            chk($sformatf("%s_rdata_hold_lat%0d", tag, lat_of(d)), rdata[d], last_rd[d]);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] dt);
        exp_t e;
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; addr = a; wdata = dt;
        e.cyc = cyc + 1; e.data = '0; e.perr = 1'b0; e.is_rd = 1'b0;
        for (int d = 0; d < 3; d++) push_exp(d, e);
        smem[a] = dt; sbad[a] = 1'b0; written[a] = 1'b1;
        @(negedge clk);
        cs = 1'b0; addr = 5'($urandom); wdata = 8'($urandom);
        @(negedge clk);
        #1 settle_checks("wr");
    endtask

    // hold = number of rising edges that see m_cs high, starting at the sampling edge.
    task automatic do_read(input logic [4:0] a, input int hold);
        exp_t e;
        int   t;
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; addr = a;
        t = cyc + 1;
        for (int d = 0; d < 3; d++) begin
            if (hold >= lat_of(d)) begin
                e.cyc = t + lat_of(d) - 1; e.data = smem[a]; e.perr = sbad[a]; e.is_rd = 1'b1;
                push_exp(d, e);
                last_rd[d] = smem[a];
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            rw = 1'($urandom); addr = 5'($urandom); wdata = 8'($urandom);
        end
        cs = 1'b0;
        @(negedge clk);
        #1 settle_checks("rd");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        for (int i = 0; i < 32; i++) begin sbad[i] = 1'b0; written[i] = 1'b0; smem[i] = '0; end
        for (int d = 0; d < 3; d++) last_rd[d] = '0;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_rdata_lat%0d", lat_of(d)), rdata[d], 0);
            chk($sformatf("reset_ready_lat%0d", lat_of(d)), ready[d], 0);
            chk($sformatf("reset_perr_lat%0d", lat_of(d)), perr[d], 0);
        end
        rst_n = 1'b1;

        do_write(5'h07, 8'hab);
        do_read(5'h07, 5);
        do_write(5'h1f, 8'h5a);
        do_read(5'h1f, 5);

        // abort: lat 2 and 4 drop the read, lat 1 completes on its first edge
        do_write(5'h05, 8'h3c);
        do_read(5'h05, 5);
        do_read(5'h07, 1);
        do_write(5'h00, 8'h11);
        do_write(5'h1f, 8'hee);
        do_read(5'h00, 5);
        do_read(5'h1f, 5);

        @(negedge clk);
        addr = 'x; wdata = 'x; rw = 'x;
        repeat (8) begin
            @(negedge clk);
            addr = 5'($urandom); wdata = 8'($urandom); rw = 1'($urandom);
        end
        do_read(5'h00, 5);
        do_read(5'h1f, 5);
        do_read(5'h07, 4);

        // asynchronous reset while lat-1 m_ready is high and lat-2/4 reads are in flight
        do_write(5'h07, 8'hc3);
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; addr = 5'h07;
        e.cyc = cyc + 1; e.data = 8'hc3; e.perr = 1'b0; e.is_rd = 1'b1;
        push_exp(0, e);
        @(negedge clk);
        #2 rst_n = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        for (int d = 0; d < 3; d++) last_rd[d] = '0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("async_rst_rdata_lat%0d", lat_of(d)), rdata[d], 0);
            chk($sformatf("async_rst_ready_lat%0d", lat_of(d)), ready[d], 0);
            chk($sformatf("async_rst_perr_lat%0d", lat_of(d)), perr[d], 0);
        end
        cs = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1 settle_checks("post_rst");
        do_read(5'h07, 5);

        for (int i = 0; i < 24; i++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 31));
            if (!written[a] || $urandom_range(0, 1) == 0) do_write(a, 8'($urandom));
            else do_read(a, $urandom_range(1, 5));
        end

`ifdef MEM_RESP_PARITY_EN
        do_write(5'h03, 8'h81);
        g_dut[0].u_dut.mem_par[3] = ~g_dut[0].u_dut.mem_par[3];
        g_dut[1].u_dut.mem_par[3] = ~g_dut[1].u_dut.mem_par[3];
        g_dut[2].u_dut.mem_par[3] = ~g_dut[2].u_dut.mem_par[3];
        sbad[3] = 1'b1;
        do_read(5'h03, 5);
        do_read(5'h07, 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
